// File: rtl/video_pkg.sv
// Shared types and address decode for the video memory responder.
package video_pkg;

    localparam logic [15:0]  TILE_BASE = 16'h4000;
    localparam logic [15:0]  PAL_BASE  = 16'h4400;
    localparam int unsigned  BANK_AW   = 10;

    typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} rd_state_t;
    typedef enum logic [1:0] {TILE, PAL, NONE} region_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wentry_t;

    // Takes only the bank-select bits; the low BANK_AW bits are the bank index.
    function automatic region_t decode_region(input logic [15:BANK_AW] hi);
        if (hi == TILE_BASE[15:BANK_AW]) return TILE;
        if (hi == PAL_BASE[15:BANK_AW])  return PAL;
        return NONE;
    endfunction

endpackage

// File: rtl/vram_responder_if.sv
// CPU-side bus of the video memory responder: buffered writes and blocking reads.
interface vram_responder_if;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_wfull;
    logic        cpu_re;
    logic        cpu_busy;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re,
        input  cpu_wfull, cpu_busy, cpu_rvalid, cpu_rdata
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
        output cpu_wfull, cpu_busy, cpu_rvalid, cpu_rdata
    );

endinterface

// File: rtl/vram_wfifo.sv
// CPU write FIFO: first-word-fall-through, synchronous reset; DEPTH must be a power of two.
module vram_wfifo
    import video_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wentry_t din,
    input  logic    pop,
    output wentry_t dout,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    wentry_t        mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A simultaneous pop frees the slot, so a push is taken even when full.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/vram_responder.sv
// Tile/palette video memory with 1-cycle video lookups and a buffered CPU port.
// Optional VRAM_CLEAR_ON_RESET_EN: zero both banks after every reset release.
module vram_responder
    import video_pkg::*;
#(
    parameter int unsigned WFIFO_DEPTH = 4,
    parameter int unsigned BANK_WORDS  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              video_active,
    input  logic [15:0]       tile_RAM_addr,
    input  logic [15:0]       palette_RAM_addr,
    output logic [7:0]        tile_ROM_addr,
    output logic [5:0]        palette_ROM_addr,
    vram_responder_if.slave   cpu
);

    logic [7:0]   tile_mem [BANK_WORDS];
    logic [5:0]   pal_mem  [BANK_WORDS];

    rd_state_t    state;
    rd_state_t    state_nxt;
    logic [15:0]  rd_addr;
    logic [7:0]   rdata_q;
    logic [7:0]   cpu_bank_rdata;

    wentry_t      fifo_dout;
    logic         fifo_full;
    logic         fifo_empty;
    logic         push;
    logic         pop;
    logic         clearing;
    logic         rd_accept;
    logic         read_issue;

    assign clearing       = (state == CLEAR);
    assign cpu.cpu_wfull  = fifo_full | clearing;
    assign cpu.cpu_busy   = (state == WAIT) | clearing;
    assign cpu.cpu_rvalid = (state == RESP);
    assign cpu.cpu_rdata  = rdata_q;

    assign push       = cpu.cpu_we & ~cpu.cpu_wfull;
    assign pop        = ~fifo_empty & ~video_active & ~clearing;
    assign rd_accept  = cpu.cpu_re & ~cpu.cpu_busy;
    // Reads wait for the FIFO to drain so they observe all earlier writes.
    assign read_issue = (state == WAIT) & fifo_empty & ~video_active;

    vram_wfifo #(.DEPTH(WFIFO_DEPTH)) u_wfifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ('{addr: cpu.cpu_addr, data: cpu.cpu_wdata}),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef VRAM_CLEAR_ON_RESET_EN
    logic [BANK_AW-1:0] clr_idx;
    logic               clr_last;

    assign clr_last = (clr_idx == BANK_AW'(BANK_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst)           clr_idx <= '0;
        else if (clearing) clr_idx <= clr_idx + 1'b1;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESP: state_nxt = rd_accept ? WAIT : IDLE;
            WAIT:       if (read_issue) state_nxt = RESP;
`ifdef VRAM_CLEAR_ON_RESET_EN
            CLEAR:      if (clr_last) state_nxt = IDLE;
`else
            CLEAR:      state_nxt = IDLE;
`endif
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef VRAM_CLEAR_ON_RESET_EN
            state <= CLEAR;
`else
            state <= IDLE;
`endif
            rd_addr <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (rd_accept)  rd_addr <= cpu.cpu_addr;
            if (read_issue) rdata_q <= cpu_bank_rdata;
        end
    end

    always_comb begin
        cpu_bank_rdata = 8'hFF;
        case (decode_region(rd_addr[15:BANK_AW]))
            TILE:    cpu_bank_rdata = tile_mem[rd_addr[BANK_AW-1:0]];
            PAL:     cpu_bank_rdata = {2'b00, pal_mem[rd_addr[BANK_AW-1:0]]};
            default: cpu_bank_rdata = 8'hFF;
        endcase
    end

    // Bank write port: the clear sweep, else the FIFO head; unmapped entries are dropped.
    always_ff @(posedge clk) begin
`ifdef VRAM_CLEAR_ON_RESET_EN
        if (clearing && !rst) begin
            tile_mem[clr_idx] <= '0;
            pal_mem[clr_idx]  <= '0;
        end else
`endif
        if (pop && !rst) begin
            case (decode_region(fifo_dout.addr[15:BANK_AW]))
                TILE:    tile_mem[fifo_dout.addr[BANK_AW-1:0]] <= fifo_dout.data;
                PAL:     pal_mem[fifo_dout.addr[BANK_AW-1:0]]  <= fifo_dout.data[5:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clearing) begin
            tile_ROM_addr    <= '0;
            palette_ROM_addr <= '0;
        end else begin
            tile_ROM_addr    <= (decode_region(tile_RAM_addr[15:BANK_AW]) == TILE)
                                ? tile_mem[tile_RAM_addr[BANK_AW-1:0]] : '0;
            palette_ROM_addr <= (decode_region(palette_RAM_addr[15:BANK_AW]) == PAL)
                                ? pal_mem[palette_RAM_addr[BANK_AW-1:0]] : '0;
        end
    end

endmodule

// File: tb/tb_vram_responder.sv
// Directed, table-driven bench for vram_responder; honours VRAM_CLEAR_ON_RESET_EN.
module tb_vram_responder;

`ifdef VRAM_CLEAR_ON_RESET_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        video_active;
    logic [15:0] tile_RAM_addr;
    logic [15:0] palette_RAM_addr;
    logic [7:0]  tile_ROM_addr;
    logic [5:0]  palette_ROM_addr;

    vram_responder_if bus ();

    vram_responder #(.WFIFO_DEPTH(4), .BANK_WORDS(1024)) dut (
        .clk              (clk),
        .rst              (rst),
        .video_active     (video_active),
        .tile_RAM_addr    (tile_RAM_addr),
        .palette_RAM_addr (palette_RAM_addr),
        .tile_ROM_addr    (tile_ROM_addr),
        .palette_ROM_addr (palette_ROM_addr),
        .cpu              (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] waddr;
        logic [7:0]  wdata;
        logic [15:0] vt;
        logic [15:0] vp;
        logic [7:0]  exp_tile;
        logic [5:0]  exp_pal;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs [7];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        step();
        bus.cpu_we    = 1'b0;
    endtask

    // Cycles counts clock edges from the strobe cycle to the rvalid cycle.
    task automatic cpu_read(input logic [15:0] a, input int budget,
                            output int cycles, output logic ok, output logic [7:0] data);
        bus.cpu_re   = 1'b1;
        bus.cpu_addr = a;
        step();
        bus.cpu_re   = 1'b0;
        cycles = 1;
        while (!bus.cpu_rvalid && cycles < budget) begin
            step();
            cycles++;
        end
        ok   = bus.cpu_rvalid;
        data = bus.cpu_rdata;
    endtask

    task automatic wait_ready(input int budget, output int cycles);
        cycles = 0;
        while (bus.cpu_busy && cycles < budget) begin
            step();
            cycles++;
        end
    endtask

    task automatic video_probe(input logic [15:0] a, input logic [7:0] exp, input string name);
        tile_RAM_addr = a;
        step();
        check(name, tile_ROM_addr, exp);
    endtask

    initial begin
        int         cyc;
        logic       ok;
        logic       seen;
        logic [7:0] data;

        vecs[0] = '{16'h4005, 8'h3C, 16'h4005, 16'h0000, 8'h3C, 6'h00, 8'h3C};
        vecs[1] = '{16'h4410, 8'hFF, 16'h4005, 16'h4410, 8'h3C, 6'h3F, 8'h3F};
        vecs[2] = '{16'h43FF, 8'h81, 16'h43FF, 16'h4410, 8'h81, 6'h3F, 8'h81};
        vecs[3] = '{16'h47FF, 8'h2A, 16'h5000, 16'h47FF, 8'h00, 6'h2A, 8'h2A};
        vecs[4] = '{16'h5000, 8'h77, 16'h4005, 16'h0000, 8'h3C, 6'h00, 8'hFF};
        vecs[5] = '{16'h4400, 8'hC1, 16'h3FFF, 16'h4400, 8'h00, 6'h01, 8'h01};
        vecs[6] = '{16'h4000, 8'h5A, 16'h4000, 16'h4800, 8'h5A, 6'h00, 8'h5A};

        rst = 1'b1;
        video_active = 1'b0;
        tile_RAM_addr = '0;
        palette_RAM_addr = '0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        bus.cpu_we = 1'b0;
        bus.cpu_re = 1'b0;
        step();
        step();
        check("rst_tile", tile_ROM_addr, 8'h00);
        check("rst_pal", palette_ROM_addr, 6'h00);
        check("rst_rdata", bus.cpu_rdata, 8'h00);
        check("rst_rvalid", bus.cpu_rvalid, 1'b0);
        check("rst_busy", bus.cpu_busy, CLR);
        check("rst_wfull", bus.cpu_wfull, CLR);
        rst = 1'b0;
        wait_ready(2000, cyc);
        check("rst_ready_cycles", cyc, CLR ? 1024 : 0);

        for (int i = 0; i < 7; i++) begin
            cpu_write(vecs[i].waddr, vecs[i].wdata);
            step();
            tile_RAM_addr    = vecs[i].vt;
            palette_RAM_addr = vecs[i].vp;
            step();
            check($sformatf("v%0d_tile", i), tile_ROM_addr, vecs[i].exp_tile);
            check($sformatf("v%0d_pal", i), palette_ROM_addr, vecs[i].exp_pal);
            cpu_read(vecs[i].waddr, 20, cyc, ok, data);
            check($sformatf("v%0d_rvalid", i), ok, 1'b1);
            check($sformatf("v%0d_rd_latency", i), cyc, 2);
            check($sformatf("v%0d_rdata", i), data, vecs[i].exp_rd);
            step();
            check($sformatf("v%0d_rvalid_pulse", i), bus.cpu_rvalid, 1'b0);
        end
        palette_RAM_addr = '0;

        // FIFO fills while the renderer owns the banks; a write into a full FIFO is lost.
        cpu_write(16'h4104, 8'h55);
        step();
        video_active = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.cpu_we    = 1'b1;
            bus.cpu_addr  = 16'h4100 + 16'(i);
            bus.cpu_wdata = 8'h10 + 8'(i);
            step();
        end
        bus.cpu_we = 1'b0;
        check("full_after_4", bus.cpu_wfull, 1'b1);
        cpu_write(16'h4104, 8'hEE);
        check("full_5th_ignored", bus.cpu_wfull, 1'b1);
        video_active = 1'b0;
        check("full_during_pop", bus.cpu_wfull, 1'b1);
        step();
        check("full_falls", bus.cpu_wfull, 1'b0);
        step();
        step();
        step();
        cpu_read(16'h4103, 20, cyc, ok, data);
        check("drain_rd_latency", cyc, 2);
        check("drain_rdata", data, 8'h13);
        step();
        video_probe(16'h4100, 8'h10, "drain_v4100");
        video_probe(16'h4102, 8'h12, "drain_v4102");
        video_probe(16'h4104, 8'h55, "drain_v4104");

        // Read held off by video_active, then ordered behind the pending write.
        video_active  = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 16'h4001;
        bus.cpu_wdata = 8'hA5;
        step();
        bus.cpu_we = 1'b0;
        bus.cpu_re = 1'b1;
        step();
        bus.cpu_re = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            seen |= bus.cpu_rvalid;
        end
        check("stall_no_rvalid", seen, 1'b0);
        check("stall_busy", bus.cpu_busy, 1'b1);
        video_active = 1'b0;
        cyc = 0;
        while (!bus.cpu_rvalid && cyc < 20) begin
            step();
            cyc++;
        end
        check("stall_release_cycles", cyc, 2);
        check("stall_rdata", bus.cpu_rdata, 8'hA5);
        step();

        // Reset mid-operation flushes the queued write and abandons the read.
        cpu_write(16'h4002, 8'h11);
        step();
        video_active = 1'b1;
        cpu_write(16'h4002, 8'h99);
        bus.cpu_re   = 1'b1;
        bus.cpu_addr = 16'h4002;
        step();
        bus.cpu_re = 1'b0;
        step();
        check("midrst_busy_before", bus.cpu_busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        video_active = 1'b0;
        check("midrst_busy", bus.cpu_busy, CLR);
        check("midrst_wfull", bus.cpu_wfull, CLR);
        seen = 1'b0;
        cyc  = 0;
        while (bus.cpu_busy && cyc < 2000) begin
            seen |= bus.cpu_rvalid;
            step();
            cyc++;
        end
        for (int i = 0; i < 4; i++) begin
            seen |= bus.cpu_rvalid;
            step();
        end
        check("midrst_ready_cycles", cyc, CLR ? 1024 : 0);
        check("midrst_no_rvalid", seen, 1'b0);
        cpu_read(16'h4002, 20, cyc, ok, data);
        check("midrst_rdata", data, CLR ? 8'h00 : 8'h11);
        step();
        video_probe(16'h4005, CLR ? 8'h00 : 8'h3C, "midrst_v4005");

`ifdef VRAM_CLEAR_ON_RESET_EN
        cpu_write(16'h4005, 8'h3C);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 500; i++) step();
        check("clr_busy_mid", bus.cpu_busy, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(2000, cyc);
        check("clr_restart_cycles", cyc, 1024);
        cpu_read(16'h4005, 20, cyc, ok, data);
        check("clr_rdata", data, 8'h00);
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
